// File: rtl/mmu_pkg.sv
// Shared constants for the MMU register file: address map,
// MMUSR bit positions and reset values.
package mmu_pkg;

   localparam logic [3:0] MMU_ADDR_CRP   = 4'd0;
   localparam logic [3:0] MMU_ADDR_SRP   = 4'd1;
   localparam logic [3:0] MMU_ADDR_TC    = 4'd2;
   localparam logic [3:0] MMU_ADDR_TT0   = 4'd3;
   localparam logic [3:0] MMU_ADDR_TT1   = 4'd4;
   localparam logic [3:0] MMU_ADDR_MMUSR = 4'd5;

   // MMUSR status bits as reported by the table walker
   localparam int MMUSR_B    = 15;
   localparam int MMUSR_L    = 14;
   localparam int MMUSR_S    = 13;
   localparam int MMUSR_W    = 11;
   localparam int MMUSR_I    = 10;
   localparam int MMUSR_M    = 9;
   localparam int MMUSR_T    = 6;
   localparam int MMUSR_N_LO = 0;
   localparam int MMUSR_N_HI = 2;

   localparam logic [31:0] MMU_RST_REG   = 32'h0000_0000;
   localparam logic [15:0] MMU_RST_MMUSR = 16'h0000;

endpackage

// File: rtl/mmu_regs.sv
// MMU control/status register file (CRP, SRP, TC, TT0/1, MMUSR).
// Define MMU_REGS_TT_EN to implement the TT0/TT1 registers.
module mmu_regs
   import mmu_pkg::*;
#(
   parameter int VA_WIDTH = 32,
   parameter int PA_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic                rd_en,
   input  logic [3:0]          addr,
   input  logic [31:0]         wr_data,
   output logic [31:0]         rd_data,
   input  logic [15:0]         mmusr_set,
   output logic [PA_WIDTH-1:0] crp,
   output logic [PA_WIDTH-1:0] srp,
   output logic [31:0]         tc,
   output logic [31:0]         tt0,
   output logic [31:0]         tt1,
   output logic [15:0]         mmusr
);

   if (VA_WIDTH > 32 || PA_WIDTH > 32) begin : g_bad_cfg
      $error("mmu_regs: VA_WIDTH and PA_WIDTH must be <= 32");
   end

   logic [PA_WIDTH-1:0] crp_q, crp_d;
   logic [PA_WIDTH-1:0] srp_q, srp_d;
   logic [31:0]         tc_q, tc_d;
   logic [15:0]         mmusr_q, mmusr_d;
   logic [31:0]         rd_data_q, rd_data_d;

   logic wr_crp, wr_srp, wr_tc, wr_sr;

   assign wr_crp = wr_en && (addr == MMU_ADDR_CRP);
   assign wr_srp = wr_en && (addr == MMU_ADDR_SRP);
   assign wr_tc  = wr_en && (addr == MMU_ADDR_TC);
   assign wr_sr  = wr_en && (addr == MMU_ADDR_MMUSR);

   always_comb begin
      crp_d = wr_crp ? wr_data[PA_WIDTH-1:0] : crp_q;
      srp_d = wr_srp ? wr_data[PA_WIDTH-1:0] : srp_q;
      tc_d  = wr_tc  ? wr_data : tc_q;
      // hardware-set bits win over a same-cycle software clear
      mmusr_d = (wr_sr ? wr_data[15:0] : mmusr_q) | mmusr_set;
   end

`ifdef MMU_REGS_TT_EN
   logic [31:0] tt0_q, tt0_d;
   logic [31:0] tt1_q, tt1_d;

   always_comb begin
      tt0_d = (wr_en && addr == MMU_ADDR_TT0) ? wr_data : tt0_q;
      tt1_d = (wr_en && addr == MMU_ADDR_TT1) ? wr_data : tt1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tt0_q <= MMU_RST_REG;
         tt1_q <= MMU_RST_REG;
      end else begin
         tt0_q <= tt0_d;
         tt1_q <= tt1_d;
      end
   end

   assign tt0 = tt0_q;
   assign tt1 = tt1_q;
`else
   assign tt0 = '0;
   assign tt1 = '0;
`endif

   // read mux samples pre-write values
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         unique case (addr)
            MMU_ADDR_CRP:   rd_data_d = 32'(crp_q);
            MMU_ADDR_SRP:   rd_data_d = 32'(srp_q);
            MMU_ADDR_TC:    rd_data_d = tc_q;
`ifdef MMU_REGS_TT_EN
            MMU_ADDR_TT0:   rd_data_d = tt0_q;
            MMU_ADDR_TT1:   rd_data_d = tt1_q;
`endif
            MMU_ADDR_MMUSR: rd_data_d = {16'h0000, mmusr_q};
            default:        rd_data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crp_q     <= MMU_RST_REG[PA_WIDTH-1:0];
         srp_q     <= MMU_RST_REG[PA_WIDTH-1:0];
         tc_q      <= MMU_RST_REG;
         mmusr_q   <= MMU_RST_MMUSR;
         rd_data_q <= MMU_RST_REG;
      end else begin
         crp_q     <= crp_d;
         srp_q     <= srp_d;
         tc_q      <= tc_d;
         mmusr_q   <= mmusr_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign crp     = crp_q;
   assign srp     = srp_q;
   assign tc      = tc_q;
   assign mmusr   = mmusr_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_mmu_regs.sv
// Scoreboard bench for mmu_regs: directed cases from the register
// rules followed by random traffic against an array-based model.
module tb_mmu_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [3:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [15:0] mmusr_set;
   logic [31:0] crp, srp, tc, tt0, tt1;
   logic [15:0] mmusr;

   always #5 clk = ~clk;

   mmu_regs #(.VA_WIDTH(32), .PA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .mmusr_set(mmusr_set), .crp(crp), .srp(srp), .tc(tc),
      .tt0(tt0), .tt1(tt1), .mmusr(mmusr)
   );

   typedef struct packed {
      logic [31:0] crp, srp, tc, tt0, tt1;
      logic [15:0] mmusr;
      logic [31:0] rd;
   } snap_t;

   snap_t       sq[$];
   logic [31:0] rq[$];

   // model: index = register address, holds the architectural value
   logic [31:0] m [0:5];
   logic [31:0] m_rd;

   int checks = 0;
   int errors = 0;

   function automatic bit mapped(int a);
`ifdef MMU_REGS_TT_EN
      return a >= 0 && a <= 5;
`else
      return a >= 0 && a <= 5 && a != 3 && a != 4;
`endif
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic step(bit r, bit we, bit re, int a,
                       logic [31:0] wd, logic [15:0] set);
      logic [31:0] nm;
      snap_t s;
      @(negedge clk);
      rst = r; wr_en = we; rd_en = re;
      addr = a[3:0]; wr_data = wd; mmusr_set = set;
      if (r) begin
         for (int i = 0; i < 6; i++) m[i] = '0;
         m_rd = '0;
      end else begin
         if (re) begin
            m_rd = mapped(a) ? m[a] : 32'h0;
            rq.push_back(m_rd);
         end
         nm = ((we && a == 5) ? {16'h0, wd[15:0]} : m[5]) | {16'h0, set};
         if (we && mapped(a) && a != 5) m[a] = wd;
         m[5] = nm;
      end
      s.crp = m[0]; s.srp = m[1]; s.tc = m[2];
`ifdef MMU_REGS_TT_EN
      s.tt0 = m[3]; s.tt1 = m[4];
`else
      s.tt0 = '0; s.tt1 = '0;
`endif
      s.mmusr = m[5][15:0];
      s.rd = m_rd;
      sq.push_back(s);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 32'h0, 16'h0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // monitor: compares every edge's outputs, pops a read result when
   // that edge carried a read strobe
   initial begin
      snap_t s;
      bit v;
      forever begin
         @(posedge clk);
         v = rd_en && !rst;
         #1;
         if (sq.size() > 0) begin
            s = sq.pop_front();
            chk("crp", crp, s.crp);
            chk("srp", srp, s.srp);
            chk("tc", tc, s.tc);
            chk("tt0", tt0, s.tt0);
            chk("tt1", tt1, s.tt1);
            chk("mmusr", {16'h0, mmusr}, {16'h0, s.mmusr});
            chk("rd_hold", rd_data, s.rd);
         end
         if (v) begin
            if (rq.size() > 0) chk("rd_data", rd_data, rq.pop_front());
            else begin
               checks++; errors++;
               $display("FAIL rd_queue: got read with no expectation");
            end
         end
      end
   end

   initial begin
      int a;
      rst = 1'b1; wr_en = 0; rd_en = 0; addr = '0;
      wr_data = '0; mmusr_set = '0;

      step(1, 1, 1, 2, 32'hDEAD_BEEF, 16'hFFFF);
      settle();
      chk("reset_tc", tc, 32'h0);
      chk("reset_mmusr", {16'h0, mmusr}, 32'h0);
      chk("reset_rd", rd_data, 32'h0);

      step(0, 1, 0, 0, 32'h1234_5678, 16'h0);
      step(0, 0, 1, 0, 32'h0, 16'h0);
      settle();
      chk("crp_direct", crp, 32'h1234_5678);
      chk("crp_read", rd_data, 32'h1234_5678);

      step(0, 1, 0, 5, 32'h0000_00FF, 16'h0);
      step(0, 1, 0, 5, 32'h0000_0000, 16'h0);
      step(0, 0, 1, 5, 32'h0, 16'h0);
      settle();
      chk("mmusr_clr_read", rd_data, 32'h0);
      step(0, 0, 0, 0, 32'h0, 16'h0080);
      idle(); idle();
      settle();
      chk("mmusr_sticky", {16'h0, mmusr}, 32'h0000_0080);
      step(0, 1, 0, 5, 32'h0, 16'h0);
      settle();
      chk("mmusr_sw_clear", {16'h0, mmusr}, 32'h0);

      step(0, 1, 0, 5, 32'h0, 16'h0004);
      settle();
      chk("mmusr_collide", {16'h0, mmusr}, 32'h0000_0004);

      step(0, 1, 0, 9, 32'hFFFF_FFFF, 16'h0);
      step(0, 0, 1, 9, 32'h0, 16'h0);
      settle();
      chk("unmapped_read", rd_data, 32'h0);
      chk("unmapped_crp", crp, 32'h1234_5678);

      step(0, 1, 0, 3, 32'hA5A5_0000, 16'h0);
      step(0, 0, 1, 3, 32'h0, 16'h0);
      settle();
`ifdef MMU_REGS_TT_EN
      chk("tt0_direct", tt0, 32'hA5A5_0000);
      chk("tt0_read", rd_data, 32'hA5A5_0000);
`else
      chk("tt0_direct", tt0, 32'h0);
      chk("tt0_read", rd_data, 32'h0);
`endif

      step(0, 1, 0, 2, 32'h1111_1111, 16'h0);
      step(0, 1, 1, 2, 32'h2222_2222, 16'h0);
      settle();
      chk("rdw_rd", rd_data, 32'h1111_1111);
      chk("rdw_tc", tc, 32'h2222_2222);

      for (int i = 0; i < 3000; i++) begin
         a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                        : int'($urandom_range(0, 5));
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1,
              a, $urandom(),
              ($urandom_range(0, 7) == 0) ? 16'(1 << $urandom_range(0, 15))
                                         : 16'h0);
      end

      idle(); idle();
      settle();
      checks++;
      if (sq.size() != 0 || rq.size() != 0) begin
         errors++;
         $display("FAIL drain: snap=%0d rd=%0d left, required 0",
                  sq.size(), rq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmu_regs.md
# mmu_regs

Software-visible MMU control/status register file for the soft 68k MMU. Holds the CPU root pointer (CRP), supervisor root pointer (SRP), translation control (TC), transparent-translation registers (TT0/TT1) and the MMU status register (MMUSR). Provides a simple single-port read/write bus for the CPU/PMOVE path and drives every register continuously to the translation/table-walk logic.

## Interface
- VA_WIDTH, 32, virtual address width; reserved for TC field checks, must be ≤ 32
- PA_WIDTH, 32, physical address width of CRP/SRP; must be ≤ 32
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- wr_en  input  1  write strobe, one write per asserted cycle
- rd_en  input  1  read strobe
- addr  input  4  register select
- wr_data  input  32  write data
- rd_data  output  32  registered read data
- mmusr_set  input  16  hardware status set mask from table walker/fault logic, ORed into MMUSR
- crp  output  PA_WIDTH  CPU root pointer
- srp  output  PA_WIDTH  supervisor root pointer
- tc  output  32  translation control
- tt0  output  32  transparent translation 0
- tt1  output  32  transparent translation 1
- mmusr  output  16  MMU status

## Operation
- Address map: 0 CRP, 1 SRP, 2 TC, 3 TT0, 4 TT1, 5 MMUSR; 6–15 unmapped.
- Write (wr_en=1): selected register loads wr_data; CRP/SRP take wr_data[PA_WIDTH-1:0]; MMUSR takes wr_data[15:0]. Unmapped writes ignored.
- MMUSR next value each cycle: (write ? wr_data[15:0] : mmusr) | mmusr_set. Hardware set always wins over a simultaneous software write; bits stay set until software writes them 0 (sticky).
- Read (rd_en=1): rd_data loads selected register, zero-extended to 32 bits (CRP/SRP when PA_WIDTH<32, MMUSR upper 16). Unmapped read returns 0.
- rd_en=0: rd_data holds its previous value.
- wr_en and rd_en together on same addr: read returns pre-write value; write still takes effect.
- Reset: crp, srp, tc, tt0, tt1, mmusr, rd_data all 0. Reset overrides wr_en, rd_en and mmusr_set in the same cycle.

## Timing
- Write latency 1: output ports show new value in the cycle after the wr_en edge.
- Read latency 1: rd_data valid after the rising edge that sampled rd_en; read of a register written in the immediately preceding cycle returns the new value.
- mmusr_set sampled every edge, no handshake; a one-cycle pulse is sufficient.
- No back-pressure; one access per cycle, both strobes may be asserted every cycle.

## Configuration
- MMU_REGS_TT_EN defined: TT0/TT1 implemented as above.
- Not defined: TT0/TT1 not stored; tt0/tt1 outputs tied 0, addresses 3–4 read 0, writes ignored (behave as unmapped).

## Structure
- Shared package mmu_pkg: register address localparams (MMU_ADDR_CRP … MMU_ADDR_MMUSR), MMUSR bit-position constants, reset-value constants.
- Flat single module; no sub-module warranted (six registers plus a read mux).

## Test plan
- Reset: assert rst one cycle -> all six register outputs 0, rd_data 0.
- CRP write/read: write addr 0 data 0x1234_5678, then rd_en addr 0 -> crp=0x1234_5678 and rd_data=0x1234_5678 after one edge.
- MMUSR sticky: write addr 5 0x0000_00FF then write 0x0000_0000, read addr 5 -> rd_data[7:0]=0x00; then pulse mmusr_set=0x0080 -> mmusr=0x0080 persists until write 0.
- Set-vs-write collision: same cycle write addr 5 0x0000 and mmusr_set=0x0004 -> mmusr=0x0004.
- Unmapped/TT: write addr 9 0xFFFF_FFFF, read addr 9 -> 0, no register changed; with MMU_REGS_TT_EN write addr 3 0xA5A5_0000 -> tt0=0xA5A5_0000, without -> tt0=0, read 0.
- Read-during-write: tc=0x1111_1111, then wr_en+rd_en addr 2 data 0x2222_2222 -> rd_data=0x1111_1111, tc=0x2222_2222.
